// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice.
//   DEFAULT_WIDTH : default operand width of the ALU datapath.
//   divState_t    : state encoding of the sequential divider FSM.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   acc     in  partial remainder (WIDTH+1 bits)
//   qMsb    in  dividend/quotient bit shifted into the accumulator
//   d       in  divisor
//   accNext out partial remainder after the trial subtraction
//   qBit    out quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic             qMsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   accNext,
  output logic             qBit
);

  logic [WIDTH:0] accShift;
  logic [WIDTH:0] trial;
  logic           unusedAccMsb;

  // The accumulator top bit always restores to 0, so it is shifted out.
  assign unusedAccMsb = acc[WIDTH];

  assign accShift = {acc[WIDTH-1:0], qMsb};
  assign trial    = accShift - {1'b0, d};

  // Trial sign clear means the divisor fit: keep the difference.
  assign qBit    = ~trial[WIDTH];
  assign accNext = qBit ? trial : accShift;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one iteration per clock.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse when results are valid
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   div_by_zero  set with done when the captured divisor was 0
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  divState_t        state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   accNext;
  logic             qBit;

  div_step #(.WIDTH(WIDTH)) uStep (
    .acc     (acc),
    .qMsb    (q[WIDTH-1]),
    .d       (d),
    .accNext (accNext),
    .qBit    (qBit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Short-circuit: report straight away without iterating.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= accNext;
          q     <= {q[WIDTH-2:0], qBit};
          count <= count + CW'(1);
          if (count == LAST_CNT) begin
            quotient    <= {q[WIDTH-2:0], qBit};
            remainder   <= accNext[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
